// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, types and helpers for the convolution arbiter
package conv_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_COEF_W     = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // Reset kernel reproduces the legacy fixed difference unit: y = a - b
  localparam int DEF_C0 = 1;
  localparam int DEF_C1 = -1;

  typedef logic signed [DEF_DATA_W-1:0]            sample_t;
  typedef logic signed [DEF_COEF_W-1:0]            coef_t;
  typedef logic signed [DEF_DATA_W+DEF_COEF_W:0]   result_t;

  // Width of a requester id; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_mac2.sv
// rtl/conv_mac2.sv - two-stage pipelined 2-tap signed multiply-add with id sideband
module conv_mac2
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ID_W   = id_width(DEF_NUM_REQ),
  parameter int RES_W  = DATA_W + COEF_W + 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_id,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [COEF_W-1:0] in_c0,
  input  logic [COEF_W-1:0] in_c1,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [RES_W-1:0]  out_data,
  output logic [1:0]        inflight
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] a_ext, b_ext, c0_ext, c1_ext;

  logic                     s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]          s1_id_q, s1_id_d;
  logic signed [PROD_W-1:0] s1_p0_q, s1_p0_d;
  logic signed [PROD_W-1:0] s1_p1_q, s1_p1_d;

  logic                     s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]          s2_id_q, s2_id_d;
  logic [RES_W-1:0]         s2_sum_q, s2_sum_d;

  // Sign-extend operands to product width so the multiply is exact
  always_comb begin
    a_ext  = {{COEF_W{in_a[DATA_W-1]}}, in_a};
    b_ext  = {{COEF_W{in_b[DATA_W-1]}}, in_b};
    c0_ext = {{DATA_W{in_c0[COEF_W-1]}}, in_c0};
    c1_ext = {{DATA_W{in_c1[COEF_W-1]}}, in_c1};
  end

  // Stage 1 forms both products; stage 2 adds them with one guard bit
  always_comb begin
    s1_valid_d = in_valid;
    s1_id_d    = in_id;
    s1_p0_d    = a_ext * c0_ext;
    s1_p1_d    = b_ext * c1_ext;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
    s2_sum_d   = {s1_p0_q[PROD_W-1], s1_p0_q} + {s1_p1_q[PROD_W-1], s1_p1_q};
  end

  // Pipeline registers; only the valids need clearing, data is cleared for tidiness
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_p0_q    <= '0;
      s1_p1_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_p0_q    <= s1_p0_d;
      s1_p1_q    <= s1_p1_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_id    = s2_id_q;
  assign out_data  = s2_sum_q;
  assign inflight  = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

endmodule

// File: rtl/conv_arbiter.sv
// rtl/conv_arbiter.sv - round-robin shared 2-tap convolution engine with tagged result FIFO
module conv_arbiter
  import conv_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int COEF_W     = DEF_COEF_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RES_W      = DATA_W + COEF_W + 1,
  parameter int ID_W       = id_width(NUM_REQ)
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cfg_we,
  input  logic [ID_W-1:0]           cfg_id,
  input  logic [COEF_W-1:0]         cfg_c0,
  input  logic [COEF_W-1:0]         cfg_c1,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RES_W-1:0]          res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [ID_W-1:0]   rr_q, rr_d;
  logic [COEF_W-1:0] c0_q [NUM_REQ];
  logic [COEF_W-1:0] c0_d [NUM_REQ];
  logic [COEF_W-1:0] c1_q [NUM_REQ];
  logic [COEF_W-1:0] c1_d [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W:0]      scan_idx;
  logic [OCC_W-1:0]   occupancy;
  logic               credit_ok;

  logic               mac_valid;
  logic [ID_W-1:0]    mac_id;
  logic [RES_W-1:0]   mac_data;
  logic [1:0]         inflight;

  logic [RES_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [RES_W-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [ID_W-1:0]    fifo_id_q [FIFO_DEPTH];
  logic [ID_W-1:0]    fifo_id_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop;

  // Credit counts results already in the pipeline so the FIFO can never overflow;
  // registered counts mean a pop only frees a slot from the following cycle
  assign occupancy = OCC_W'(cnt_q) + OCC_W'(inflight);
  assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);

  // Scan requesters starting at the rr pointer and grant the first valid one
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && reset && credit_ok && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_any                   = 1'b1;
        grant_id                    = scan_idx[ID_W-1:0];
        grant[scan_idx[ID_W-1:0]]   = 1'b1;
      end
    end
  end

  assign req_ready = grant;

  // Pointer moves just past the requester that was served; holds otherwise
  always_comb begin
    rr_d = rr_q;
    if (grant_any) begin
      rr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Coefficient writes land at the edge, so a same-cycle accept sees the old pair
  always_comb begin
    c0_d = c0_q;
    c1_d = c1_q;
    if (cfg_we && (int'(cfg_id) < NUM_REQ)) begin
      c0_d[cfg_id] = cfg_c0;
      c1_d[cfg_id] = cfg_c1;
    end
  end

  // Arbiter pointer and coefficient file state
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        c0_q[i] <= COEF_W'(DEF_C0);
        c1_q[i] <= COEF_W'(DEF_C1);
      end
    end else begin
      rr_q <= rr_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
    end
  end

  conv_mac2 #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ID_W   (ID_W),
    .RES_W  (RES_W)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant_any),
    .in_id     (grant_id),
    .in_a      (req_a[grant_id*DATA_W +: DATA_W]),
    .in_b      (req_b[grant_id*DATA_W +: DATA_W]),
    .in_c0     (c0_q[grant_id]),
    .in_c1     (c1_q[grant_id]),
    .out_valid (mac_valid),
    .out_id    (mac_id),
    .out_data  (mac_data),
    .inflight  (inflight)
  );

  assign push = mac_valid;
  assign pop  = res_valid & res_ready;

  // FIFO bookkeeping; credit guarantees a push never meets a full FIFO
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_data_d[wr_ptr_q] = mac_data;
      fifo_id_d[wr_ptr_q]   = mac_id;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO pointers and count; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_id_q   <= fifo_id_d;
  end

  assign res_valid = (cnt_q != '0);
  assign res_data  = res_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign res_id    = res_valid ? fifo_id_q[rd_ptr_q] : '0;
  assign busy      = (inflight != 2'd0) || res_valid;

endmodule
